apb_master_bridge: RTL

//  Initiator end of the APB bus. Accepts read/write commands on a valid/ready

---
 rtl/apb_master_pkg.sv | 19 +
 rtl/apb_cmd_fifo.sv | 56 +++++
 rtl/apb_master_bridge.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/apb_master_pkg.sv
// Shared types and default widths for the APB initiator bridge.
package apb_master_pkg;

  localparam int APB_ADDR_WIDTH = 32;
  localparam int APB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_mst_state_t;

  typedef struct packed {
    logic                      write;
    logic [APB_ADDR_WIDTH-1:0] addr;
    logic [APB_DATA_WIDTH-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO. Flushing only clears pointers and count;
// the storage itself carries no reset.
import apb_master_pkg::*;

module apb_cmd_fifo #(
  parameter type T     = apb_cmd_t,
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          PClk,
  input  logic          Rst,
  input  logic          push,
  input  T              wr_data,
  input  logic          pop,
  output T              rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  T              mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_ok;
  logic          pop_ok;

  // A full FIFO refuses a push even when a pop happens on the same edge.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge PClk) begin
    if (Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Entry storage.
  always_ff @(posedge PClk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/apb_master_bridge.sv
// APB initiator: queues commands, runs one SETUP/ACCESS transfer per command
// in order, and holds read data for a valid/ready consumer.
//
//   state  | meaning
//   IDLE   | bus idle, PSel=0, waiting for an issuable head command
//   SETUP  | PSel=1, PEnable=0, address/direction/data presented
//   ACCESS | PSel=1, PEnable=1, transfer completes at the next edge
import apb_master_pkg::*;

module apb_master_bridge #(
  parameter int AW    = APB_ADDR_WIDTH,
  parameter int DW    = APB_DATA_WIDTH,
  parameter int DEPTH = 4,
  parameter int XCW   = 16
) (
  input  logic           PClk,
  input  logic           Rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic           cmd_write,
  input  logic [AW-1:0]  cmd_addr,
  input  logic [DW-1:0]  cmd_wdata,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [DW-1:0]  rsp_rdata,
  output logic           PSel,
  output logic           PEnable,
  output logic           PWrite,
  output logic [AW-1:0]  PAddr,
  output logic [DW-1:0]  PWData,
  input  logic [DW-1:0]  PRData,
  output logic           busy,
  output logic [XCW-1:0] xfer_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  apb_mst_state_t state_q, state_d;
  cmd_t           push_cmd, head;
  logic           fifo_full, fifo_empty, issue;
  logic [CW-1:0]  fifo_count;

  logic           psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [AW-1:0]  paddr_q, paddr_d;
  logic [DW-1:0]  pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [XCW-1:0] xfer_count_q, xfer_count_d;

  assign push_cmd = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};

  apb_cmd_fifo #(.T(cmd_t), .DEPTH(DEPTH)) u_fifo (
    .PClk    (PClk),
    .Rst     (Rst),
    .push    (cmd_valid),
    .wr_data (push_cmd),
    .pop     (issue),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Issue decision: a read must not land on an unconsumed response. In ACCESS
  // a completing read occupies the response slot itself.
  always_comb begin
    issue = 1'b0;
    case (state_q)
      IDLE:    issue = ~fifo_empty & (head.write | ~rsp_valid_q);
      ACCESS:  issue = ~fifo_empty &
                       (head.write | ~(~pwrite_q | (rsp_valid_q & ~rsp_ready)));
      default: issue = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge PClk) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = issue ? SETUP : IDLE;
      SETUP:   state_d = ACCESS;
      ACCESS:  state_d = issue ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/next-value logic for the registered bus, response and counter.
  always_comb begin
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    xfer_count_d = xfer_count_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_valid_d  = rsp_valid_q & ~rsp_ready;
    case (state_q)
      SETUP: penable_d = 1'b1;
      ACCESS: begin
        xfer_count_d = xfer_count_q + XCW'(1);
        if (!pwrite_q) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = PRData;
        end
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
      default: ;
    endcase
    if (issue) begin
      psel_d    = 1'b1;
      penable_d = 1'b0;
      pwrite_d  = head.write;
      paddr_d   = head.addr;
      pwdata_d  = head.wdata;
    end
  end

  // Registered outputs.
  always_ff @(posedge PClk) begin
    if (Rst) begin
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      xfer_count_q <= '0;
    end else begin
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  assign cmd_ready  = ~fifo_full;
  assign busy       = (fifo_count != '0) | (state_q != IDLE);
  assign PSel       = psel_q;
  assign PEnable    = penable_q;
  assign PWrite     = pwrite_q;
  assign PAddr      = paddr_q;
  assign PWData     = pwdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign xfer_count = xfer_count_q;

endmodule
